// File: rtl/microc_stk.sv
// Parametrised single-cycle microcontroller datapath: 16-entry regfile, ALU with zero/carry
// flags, program counter and a hardware return stack with sticky overflow/underflow reporting.
module microc_stk #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   instr,
    output logic [PC_W-1:0]               pc,
    output logic [5:0]                    opcode,
    output logic                          z,
    output logic                          c,
    input  logic                          s_inm,
    input  logic                          we3,
    input  logic                          wez,
    input  logic [2:0]                    op,
    input  logic [1:0]                    pc_sel,
    output logic [$clog2(STACK_DEPTH):0]  stk_level,
    output logic                          stk_err
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_r [16];
    logic [PC_W-1:0]   stk_mem_r [STACK_DEPTH];
    logic [PC_W-1:0]   pc_r, pc_next_s, pc_inc_s, target_s;
    logic [LVL_W-1:0]  level_r, level_dec_s;
    logic              z_r, c_r, stk_err_r;
    logic              push_s, pop_s, err_set_s;
    logic [3:0]        ra1_s, ra2_s, wa3_s;
    logic [DATA_W-1:0] rd1_s, rd2_s, imm_s, alu_res_s, wd3_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic              alu_c_s;

    assign ra1_s       = instr[11:8];
    assign ra2_s       = instr[7:4];
    assign wa3_s       = instr[3:0];
    assign imm_s       = DATA_W'(instr[11:4]);
    assign target_s    = instr[PC_W-1:0];
    assign rd1_s       = (ra1_s == 4'd0) ? {DATA_W{1'b0}} : regs_r[ra1_s];
    assign rd2_s       = (ra2_s == 4'd0) ? {DATA_W{1'b0}} : regs_r[ra2_s];
    assign wd3_s       = s_inm ? imm_s : alu_res_s;
    assign pc_inc_s    = pc_r + PC_ONE;
    assign level_dec_s = level_r - LVL_ONE;

    // ALU: the extra MSB of sum/diff yields carry-out and borrow (A<B) respectively
    always_comb begin
        sum_s     = {1'b0, rd1_s} + {1'b0, rd2_s};
        diff_s    = {1'b0, rd1_s} - {1'b0, rd2_s};
        alu_res_s = rd1_s;
        alu_c_s   = 1'b0;
        case (op)
            3'b000:  alu_res_s = rd1_s;
            3'b001:  alu_res_s = ~rd1_s;
            3'b010:  begin alu_res_s = sum_s[DATA_W-1:0];  alu_c_s = sum_s[DATA_W];  end
            3'b011:  begin alu_res_s = diff_s[DATA_W-1:0]; alu_c_s = diff_s[DATA_W]; end
            3'b100:  alu_res_s = rd1_s & rd2_s;
            3'b101:  alu_res_s = rd1_s | rd2_s;
            3'b110:  alu_res_s = {DATA_W{1'b0}} - rd1_s;
            3'b111:  alu_res_s = {DATA_W{1'b0}} - rd2_s;
            default: alu_res_s = rd1_s;
        endcase
    end

    // Next-PC select; a CALL on a full stack or RET on an empty one degrades to pc+1
    always_comb begin
        pc_next_s = pc_inc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        case (pc_sel)
            2'b00: pc_next_s = pc_inc_s;
            2'b01: pc_next_s = target_s;
            2'b10: begin
                if (level_r == LVL_FULL) begin
                    err_set_s = 1'b1;
                end else begin
                    push_s    = 1'b1;
                    pc_next_s = target_s;
                end
            end
            2'b11: begin
                if (level_r == {LVL_W{1'b0}}) begin
                    err_set_s = 1'b1;
                end else begin
                    pop_s     = 1'b1;
                    pc_next_s = stk_mem_r[level_dec_s[PTR_W-1:0]];
                end
            end
            default: pc_next_s = pc_inc_s;
        endcase
    end

    // Program counter, return stack and sticky stack error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r      <= {PC_W{1'b0}};
            level_r   <= {LVL_W{1'b0}};
            stk_err_r <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_mem_r[i] <= {PC_W{1'b0}};
            end
        end else begin
            pc_r <= pc_next_s;
            if (push_s) begin
                stk_mem_r[level_r[PTR_W-1:0]] <= pc_inc_s;
                level_r <= level_r + LVL_ONE;
            end else if (pop_s) begin
                level_r <= level_dec_s;
            end
            if (err_set_s) begin
                stk_err_r <= 1'b1;
            end
        end
    end

    // Zero/carry flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_r <= 1'b0;
            c_r <= 1'b0;
        end else if (wez) begin
            z_r <= (alu_res_s == {DATA_W{1'b0}});
            c_r <= alu_c_s;
        end
    end

    // Register file; R0 is never written so it stays hard-wired to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we3 && (wa3_s != 4'd0)) begin
            regs_r[wa3_s] <= wd3_s;
        end
    end

    assign pc        = pc_r;
    assign opcode    = instr[15:10];
    assign z         = z_r;
    assign c         = c_r;
    assign stk_level = level_r;
    assign stk_err   = stk_err_r;
endmodule

// File: tb/tb_microc_stk.sv
// Self-checking bench for microc_stk: reference model feeds a scoreboard queue of expected
// architectural state, compared one cycle later against the DUT outputs.
module tb_microc_stk;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [9:0]  pc;
    logic [5:0]  opcode;
    logic        z, c;
    logic        s_inm = 1'b0, we3 = 1'b0, wez = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  pc_sel = 2'd0;
    logic [3:0]  stk_level;
    logic        stk_err;

    microc_stk dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .opcode(opcode),
        .z(z), .c(c), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
        .pc_sel(pc_sel), .stk_level(stk_level), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  pc;
        logic        z;
        logic        c;
        logic [3:0]  lvl;
        logic        err;
        logic [5:0]  opc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  m_reg [16];
    logic [9:0]  m_stk[$];
    logic [9:0]  m_pc;
    logic        m_z, m_c, m_err;
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_stk.delete();
        m_pc = 10'h000; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic [15:0] mk_imm(input logic [7:0] imm, input logic [3:0] wa);
        return {4'h0, imm, wa};
    endfunction

    function automatic logic [15:0] mk_rrr(input logic [3:0] a, input logic [3:0] b, input logic [3:0] wa);
        return {4'h0, a, b, wa};
    endfunction

    function automatic logic [15:0] mk_tgt(input logic [9:0] t);
        return {6'h00, t};
    endfunction

    // Drive one instruction, advance the model, push expectation, then compare after the edge
    task automatic step(input logic [15:0] ins, input logic si, input logic w3, input logic wz,
                        input logic [2:0] o, input logic [1:0] ps);
        logic [7:0] a, b, r;
        logic       cy;
        logic [9:0] nxt;
        exp_t       e;
        instr = ins; s_inm = si; we3 = w3; wez = wz; op = o; pc_sel = ps;
        a  = m_reg[ins[11:8]];
        b  = m_reg[ins[7:4]];
        cy = 1'b0;
        case (o)
            3'd0: r = a;
            3'd1: r = 8'hFF ^ a;
            3'd2: begin r = a + b; cy = (({1'b0, a} + {1'b0, b}) > 9'd255); end
            3'd3: begin r = a - b; cy = (a < b); end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = 8'd0 - a;
            default: r = 8'd0 - b;
        endcase
        if (wz) begin m_z = (r == 8'h00); m_c = cy; end
        if (w3 && ins[3:0] != 4'd0) m_reg[ins[3:0]] = si ? ins[11:4] : r;
        nxt = m_pc + 10'd1;
        case (ps)
            2'd0: m_pc = nxt;
            2'd1: m_pc = ins[9:0];
            2'd2: begin
                if (m_stk.size() == 8) begin m_err = 1'b1; m_pc = nxt; end
                else begin m_stk.push_back(nxt); m_pc = ins[9:0]; end
            end
            default: begin
                if (m_stk.size() == 0) begin m_err = 1'b1; m_pc = nxt; end
                else m_pc = m_stk.pop_back();
            end
        endcase
        e.pc = m_pc; e.z = m_z; e.c = m_c; e.lvl = 4'(m_stk.size()); e.err = m_err;
        e.opc = ins[15:10];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_pc", pc, e.pc);
        check_eq("sb_z", z, e.z);
        check_eq("sb_c", c, e.c);
        check_eq("sb_lvl", stk_level, e.lvl);
        check_eq("sb_err", stk_err, e.err);
        check_eq("sb_opc", opcode, e.opc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 10'h000);
        check_eq("rst_z", z, 1'b0);
        check_eq("rst_c", c, 1'b0);
        check_eq("rst_lvl", stk_level, 4'd0);
        check_eq("rst_err", stk_err, 1'b0);
        reset = 1'b1;

        // Immediate load and add
        step(mk_imm(8'h5A, 4'd3), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_rrr(4'd3, 4'd3, 4'd4), 1'b0, 1'b1, 1'b1, 3'd2, 2'd0);
        check_eq("t1_add_z", z, 1'b0);
        check_eq("t1_add_c", c, 1'b0);
        step(mk_imm(8'hB4, 4'd5), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_rrr(4'd4, 4'd5, 4'd0), 1'b0, 1'b0, 1'b1, 3'd3, 2'd0);
        check_eq("t1_r4_is_b4", z, 1'b1);

        // Carry, borrow, logic-op clears carry
        step(mk_imm(8'hFF, 4'd1), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_imm(8'h01, 4'd2), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_rrr(4'd1, 4'd2, 4'd8), 1'b0, 1'b1, 1'b1, 3'd2, 2'd0);
        check_eq("t2_add_z", z, 1'b1);
        check_eq("t2_add_c", c, 1'b1);
        step(mk_imm(8'h01, 4'd1), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_imm(8'h02, 4'd2), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_rrr(4'd1, 4'd2, 4'd6), 1'b0, 1'b1, 1'b1, 3'd3, 2'd0);
        check_eq("t2_sub_c", c, 1'b1);
        check_eq("t2_sub_z", z, 1'b0);
        step(mk_imm(8'hFF, 4'd7), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        check_eq("t2_flag_hold", c, 1'b1);
        step(mk_rrr(4'd6, 4'd7, 4'd0), 1'b0, 1'b0, 1'b1, 3'd3, 2'd0);
        check_eq("t2_r6_is_ff", z, 1'b1);
        step(mk_rrr(4'd1, 4'd2, 4'd0), 1'b0, 1'b0, 1'b1, 3'd3, 2'd0);
        step(mk_rrr(4'd1, 4'd2, 4'd0), 1'b0, 1'b0, 1'b1, 3'd4, 2'd0);
        check_eq("t2_and_c", c, 1'b0);

        // CALL / RET round trip
        step(mk_tgt(10'h005), 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
        step(mk_tgt(10'h040), 1'b0, 1'b0, 1'b0, 3'd0, 2'd2);
        check_eq("t3_call_pc", pc, 10'h040);
        check_eq("t3_call_lvl", stk_level, 4'd1);
        step(mk_tgt(10'h000), 1'b0, 1'b0, 1'b0, 3'd0, 2'd3);
        check_eq("t3_ret_pc", pc, 10'h006);
        check_eq("t3_ret_lvl", stk_level, 4'd0);
        check_eq("t3_ret_err", stk_err, 1'b0);

        // Fill the stack, overflow, then unwind LIFO
        for (int i = 0; i < 8; i++)
            step(mk_tgt(10'h100 + 10'(i * 16)), 1'b0, 1'b0, 1'b0, 3'd0, 2'd2);
        check_eq("t4_full_lvl", stk_level, 4'd8);
        step(mk_tgt(10'h300), 1'b0, 1'b0, 1'b0, 3'd0, 2'd2);
        check_eq("t4_ovf_pc", pc, 10'h171);
        check_eq("t4_ovf_lvl", stk_level, 4'd8);
        check_eq("t4_ovf_err", stk_err, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(mk_tgt(10'h000), 1'b0, 1'b0, 1'b0, 3'd0, 2'd3);
            if (i < 7) check_eq("t4_lifo_pc", pc, 10'h161 - 10'(i * 16));
        end

        // Randomised mix of all operations against the model
        for (int i = 0; i < 80; i++)
            step(16'($urandom_range(0, 65535)), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom), 2'($urandom));

        // Stack underflow and sticky error
        do_reset();
        step(mk_tgt(10'h010), 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
        step(mk_tgt(10'h000), 1'b0, 1'b0, 1'b0, 3'd0, 2'd3);
        check_eq("t5_unf_pc", pc, 10'h011);
        check_eq("t5_unf_err", stk_err, 1'b1);
        repeat (3) step(mk_tgt(10'h000), 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        check_eq("t5_err_sticky", stk_err, 1'b1);
        do_reset();
        check_eq("t5_rst_pc", pc, 10'h000);
        check_eq("t5_rst_err", stk_err, 1'b0);

        // PC wrap, R0 write discard, asynchronous mid-cycle reset
        step(mk_tgt(10'h3FF), 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
        step(mk_tgt(10'h000), 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        check_eq("t6_wrap_pc", pc, 10'h000);
        step(mk_imm(8'h77, 4'd0), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_rrr(4'd0, 4'd0, 4'd9), 1'b0, 1'b1, 1'b1, 3'd2, 2'd0);
        check_eq("t6_r0_zero", z, 1'b1);
        step(mk_imm(8'hFF, 4'd1), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_imm(8'h01, 4'd2), 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
        step(mk_rrr(4'd1, 4'd2, 4'd0), 1'b0, 1'b0, 1'b1, 3'd2, 2'd0);
        step(mk_tgt(10'h200), 1'b0, 1'b0, 1'b0, 3'd0, 2'd2);
        check_eq("t6_pre_lvl", stk_level, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_async_pc", pc, 10'h000);
        check_eq("t6_async_z", z, 1'b0);
        check_eq("t6_async_c", c, 1'b0);
        check_eq("t6_async_lvl", stk_level, 4'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(mk_rrr(4'd1, 4'd0, 4'd0), 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
        check_eq("t6_regs_cleared", z, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
